// File: rtl/upg_word_assembler.sv
// Assembles a UART byte stream (16-bit word count, then little-endian 32-bit words)
// into program-ROM write strobes, with an inter-byte timeout inside a frame.
module upg_word_assembler #(
   parameter int ADDR_WIDTH     = 14,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  iUpgClock,
   input  logic                  iUpgResetN,
   input  logic                  iRxValid,
   input  logic [7:0]            iRxByte,
   output logic                  oUpgWriteEnable,
   output logic [ADDR_WIDTH-1:0] oUpgWriteAddress,
   output logic [31:0]           oUpgWriteData,
   output logic                  oUpgDone,
   output logic                  oUpgError,
   output logic                  oBusy,
   output logic [ADDR_WIDTH:0]   oWordsWritten
);

   // Wide enough to compare a 16-bit count against 2^ADDR_WIDTH without truncation.
   localparam int CMP_WIDTH   = ADDR_WIDTH + 17;
   localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      CNT_HI,
      DATA,
      DONE,
      ERROR
   } fsmState;

   fsmState                state;
   fsmState                nextState;
   logic [15:0]            wordCount;
   logic [1:0]             byteIndex;
   logic [TIMER_WIDTH-1:0] timeoutCount;
   logic [31:0]            shiftData;
   logic                   writeEnable;
   logic [ADDR_WIDTH-1:0]  writeAddress;
   logic [ADDR_WIDTH:0]    wordsWritten;

   logic                   byteAccept;
   logic [15:0]            fullCount;
   logic                   countTooLarge;
   logic                   timeoutHit;
   logic                   lastWrite;

   assign fullCount     = {iRxByte, wordCount[7:0]};
   assign countTooLarge = CMP_WIDTH'(fullCount) > (CMP_WIDTH'(1) << ADDR_WIDTH);
   assign timeoutHit    = (timeoutCount == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
   // The strobe cycle of the N-th word is the one that finishes the frame.
   assign lastWrite     = writeEnable &&
                          (CMP_WIDTH'(wordsWritten) + CMP_WIDTH'(1) == CMP_WIDTH'(wordCount));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge iUpgClock) begin
      if (!iUpgResetN) state <= IDLE;
      else             state <= nextState;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (iRxValid) nextState = CNT_HI;
         end
         CNT_HI: begin
            if (iRxValid) begin
               if (fullCount == 16'd0) nextState = DONE;
               else if (countTooLarge) nextState = ERROR;
               else                    nextState = DATA;
            end else if (timeoutHit) begin
               nextState = ERROR;
            end
         end
         DATA: begin
            if (lastWrite)                     nextState = DONE;
            else if (!iRxValid && timeoutHit)  nextState = ERROR;
         end
         default: nextState = state;
      endcase
   end

   always_comb begin
      oBusy      = 1'b0;
      oUpgDone   = 1'b0;
      oUpgError  = 1'b0;
      byteAccept = 1'b0;
      case (state)
         IDLE:         byteAccept = iRxValid;
         CNT_HI, DATA: begin
            oBusy      = 1'b1;
            byteAccept = iRxValid;
         end
         DONE:         oUpgDone  = 1'b1;
         ERROR:        oUpgError = 1'b1;
         default:      ;
      endcase
   end

   // NOTE: reset is synchronous and clears the whole datapath, so a partial word never survives it.
   always_ff @(posedge iUpgClock) begin
      if (!iUpgResetN) begin
         wordCount    <= '0;
         byteIndex    <= '0;
         timeoutCount <= '0;
         shiftData    <= '0;
         writeEnable  <= 1'b0;
         writeAddress <= '0;
         wordsWritten <= '0;
      end else begin
         writeEnable <= 1'b0;

         if (byteAccept) begin
            case (state)
               IDLE:   wordCount[7:0]  <= iRxByte;
               CNT_HI: wordCount[15:8] <= iRxByte;
               DATA: begin
                  if (!lastWrite) begin
                     shiftData   <= {iRxByte, shiftData[31:8]};
                     byteIndex   <= byteIndex + 2'd1;
                     writeEnable <= (byteIndex == 2'd3);
                  end
               end
               default: ;
            endcase
         end

         if (writeEnable) begin
            writeAddress <= writeAddress + ADDR_WIDTH'(1);
            wordsWritten <= wordsWritten + (ADDR_WIDTH + 1)'(1);
         end

         // Counts only idle cycles that keep the FSM in a frame state; entry and bytes restart it.
         if (oBusy && !iRxValid && nextState == state) timeoutCount <= timeoutCount + TIMER_WIDTH'(1);
         else                                          timeoutCount <= '0;
      end
   end

   assign oUpgWriteEnable  = writeEnable;
   assign oUpgWriteAddress = writeAddress;
   assign oUpgWriteData    = shiftData;
   assign oWordsWritten    = wordsWritten;

endmodule

// File: doc/upg_word_assembler.md
UPG_WORD_ASSEMBLER -- requirements
Module: upg_word_assembler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14: width of the program-ROM word address.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle clocks between bytes inside a frame (100 ms at 10 MHz).
REQ-003 SHALL have port iUpgClock, input, 1 bit: the single clock, UPG domain (10 MHz).
REQ-004 SHALL have port iUpgResetN, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port iRxValid, input, 1 bit: one-cycle strobe from the UART receiver; the byte is valid this cycle.
REQ-006 SHALL have port iRxByte, input, 8 bits: received byte, sampled only when iRxValid=1.
REQ-007 SHALL have port oUpgWriteEnable, output, 1 bit: one-cycle ROM write strobe.
REQ-008 SHALL have port oUpgWriteAddress, output, ADDR_WIDTH bits: word address for the current write.
REQ-009 SHALL have port oUpgWriteData, output, 32 bits: assembled instruction word.
REQ-010 SHALL have port oUpgDone, output, 1 bit: programming complete; sticky.
REQ-011 SHALL have port oUpgError, output, 1 bit: frame aborted; sticky.
REQ-012 SHALL have port oBusy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port oWordsWritten, output, ADDR_WIDTH+1 bits: count of write strobes issued.

Function
REQ-014 SHALL implement the FSM states IDLE, CNT_HI, DATA, DONE and ERROR.
REQ-015 Frame format SHALL be: a 16-bit word count N, little-endian (low byte first), followed by 4*N data bytes.
REQ-016 Data bytes SHALL be little-endian within each word: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-017 IDLE SHALL capture a valid byte as N[7:0] and go to CNT_HI; there is no timeout in IDLE.
REQ-018 CNT_HI SHALL capture a valid byte as N[15:8] and then branch as follows:
  - N=0 -> DONE.
  - N > 2^ADDR_WIDTH -> ERROR.
  - otherwise -> DATA.
REQ-019 DATA SHALL use a 2-bit byte index that wraps 3->0.
REQ-020 On acceptance of the 4th byte of a word at edge t, oUpgWriteEnable SHALL be high for exactly the cycle after t, with the complete word and its address stable on the outputs during that cycle.
REQ-021 The first word SHALL be written to address 0; the address SHALL increment by 1 after each write strobe.
REQ-022 oWordsWritten SHALL increment on the same edge that ends each write strobe.
REQ-023 After the N-th write strobe, the FSM SHALL enter DONE and oUpgDone SHALL rise on the edge ending that strobe.
REQ-024 The inter-byte timeout counter SHALL clear on entry to CNT_HI or DATA and on every accepted byte, and count otherwise in those states.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1 in CNT_HI or DATA, the FSM SHALL enter ERROR; a byte arriving in that same cycle SHALL win and clear the counter.
REQ-026 DONE and ERROR SHALL be absorbing until reset; bytes received in them SHALL be ignored and SHALL produce no write strobe.
REQ-027 oBusy SHALL be 1 in CNT_HI and DATA, and 0 otherwise.
REQ-028 oUpgDone and oUpgError SHALL never both be 1.
REQ-029 A partial word SHALL never be written.

Reset
REQ-030 iUpgResetN=0 at a clock edge SHALL force the following on that edge: state IDLE; all outputs 0; byte index, timeout counter, N and the data shift register cleared.
REQ-031 Reset mid-frame SHALL discard the partial word; after release, the next byte SHALL be treated as N[7:0].

Verification
REQ-032 Scenario: bytes 01 00 EF BE AD DE -> one strobe, addr 0, data 0xDEADBEEF; oUpgDone=1 on the next edge; oWordsWritten=1.
REQ-033 Scenario: bytes 00 00 -> oUpgDone=1 one edge after the 2nd byte; no strobe.
REQ-034 Scenario: N=3 with 12 data bytes, then 4 extra bytes -> strobes at addr 0,1,2 with the correct words; extra bytes ignored; oWordsWritten=3.
REQ-035 Scenario: bytes 01 40 (N=0x4001) -> oUpgError=1; no strobe; later bytes ignored.
REQ-036 Scenario: TIMEOUT_CYCLES=100, N=2, 5 data bytes then silence -> one strobe (addr 0); oUpgError=1 exactly 100 clocks after the last byte.
REQ-037 Scenario: iUpgResetN low after 6 data bytes of N=2 -> all outputs 0; resending a full N=1 frame yields addr 0 written, oUpgDone=1.
